turn_cmd_queue: RTL and testbench
=================================

Name: turn_cmd_queue

Overview:
- Parametrised successor to the snake game's left/right command latch.
- Accepts one-cycle direction pulses on the fast CLOCK domain for all four directions, filters out redundant and reversing turns, and buffers up to DEPTH pending turns.
- On each rising edge of the game tick (SLOW_CLOCK), pops one turn into the committed heading.
- Sits between the button debouncers/pulse generators and the snake movement engine.

Parameters:
- DEPTH, 2: number of pending turn entries; legal range 1..8.
- RESET_DIR, 2'd3 (RIGHT): heading loaded on reset.
- CNT_W, $clog2(DEPTH+1): width of the occupancy output.

Ports:
- CLOCK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- SLOW_CLOCK  in  1  game tick level, synchronous to CLOCK; each rising edge is one game step.
- enable  in  1  request to arm the step-enable flag.
- up_pulse, down_pulse, left_pulse, right_pulse  in  1 each  one-cycle turn requests.
- E  out  1  step-enable flag; set by enable, cleared on tick.
- heading  out  2  committed direction (dir_t).
- tick  out  1  one-cycle pulse, asserted the cycle after a SLOW_CLOCK rising edge is sampled.
- q_count  out  CNT_W  pending entries.
- drop  out  1  one-cycle pulse when a request is discarded.

Behaviour:
- Reset state: heading=RESET_DIR, queue empty, q_count=0, E=1, tick=0, drop=0.
- Reset state (cont.): slow_prev=1, so a SLOW_CLOCK held high through reset does not fire a tick.
- Tick detection: rise = SLOW_CLOCK & ~slow_prev. slow_prev is registered every cycle. tick is registered from rise (1-cycle latency).
- Request encode: if several pulses are high in one cycle, priority is up > down > left > right; only one request is considered per cycle.
- Reference direction: the tail entry if q_count>0, else the current heading.
- Filter: a request equal to the reference, or equal to opposite(reference), is discarded and drop pulses for 1 cycle.
- Push: an unfiltered request is written at the tail when q_count<DEPTH. If the queue is full, the request is discarded and drop pulses.
- Pop: on rise with q_count>0, heading<=head entry and the head advances. With the queue empty, heading holds.
- Pop timing: heading updates in the same cycle tick is registered, so heading and tick change together.
- Push and pop in the same cycle: both occur and q_count is unchanged.
  - Full queue: the push is accepted, because the pop frees a slot.
  - q_count==1: the filter still compares against the tail, i.e. the entry being popped. This is consistent because that entry becomes the new heading.
- Pointers: read and write pointers wrap modulo DEPTH. q_count is kept separately to distinguish full from empty.
- E behaviour: enable=1 sets E=1. rise clears E=0, and clear wins if both occur in the same cycle.
- Reset mid-operation: the queue is flushed and all state returns to reset values on the next edge; in-flight pulses in that cycle are ignored.

Optional Feature:
- Macro: TURN_QUEUE_DROP_COUNT_EN.
- Defined: adds output drop_count[7:0], which increments on every drop pulse, saturates at 255 and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package snake_pkg:
  - typedef enum logic[1:0] dir_t {UP=0, DOWN=1, LEFT=2, RIGHT=3}.
  - Function opposite(d) = d ^ 2'b01.
  - Constant DIR_W=2.
- Sub-module rise_detect: one registered bit with a parametrised reset value, outputting the rise pulse. It is reused by the tick logic and by future input blocks.
- The queue storage stays inline, since it is small.

Test Plan:
- Reset with heading=RIGHT, then up_pulse, then a SLOW_CLOCK rise -> q_count 0→1; heading=UP with tick high the cycle after the edge; q_count=0.
- heading=RIGHT, then left_pulse -> drop=1, q_count=0. Then right_pulse -> drop=1.
- DEPTH=2, heading=RIGHT, pulses up, left, down -> entries UP, LEFT; down is dropped as full. Two ticks -> heading UP then LEFT.
- Queue full [UP, LEFT], then down_pulse in the same cycle as a tick pop -> pop UP; DOWN is accepted; q_count stays 2.
- Simultaneous up_pulse+left_pulse with heading=RIGHT -> only UP is enqueued.
- E checks:
  - enable in the same cycle as a rise -> E=0.
  - SLOW_CLOCK held high during RESET release -> no tick.
  - RESET asserted with q_count=2 -> q_count=0, heading=RESET_DIR next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared direction type and helpers for the snake game control path.
package snake_pkg;

   localparam int unsigned DIR_W = 2;

   typedef enum logic [DIR_W-1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
   function automatic dir_t opposite(input dir_t d);
      return dir_t'(d ^ 2'b01);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-register rising-edge detector; the reset value selects whether a level
// already high at reset release counts as an edge.
module rise_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev <= RESET_VAL;
      end else begin
         r_prev <= i_sig;
      end
   end

   assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/turn_cmd_queue.sv
// Filters four-way turn pulses and queues up to DEPTH of them, committing one per game tick.
// Optional TURN_QUEUE_DROP_COUNT_EN adds a saturating drop_count[7:0] output.
module turn_cmd_queue
   import snake_pkg::*;
#(
   parameter int unsigned DEPTH     = 2,
   parameter dir_t        RESET_DIR = RIGHT,
   parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             SLOW_CLOCK,
   input  logic             enable,
   input  logic             up_pulse,
   input  logic             down_pulse,
   input  logic             left_pulse,
   input  logic             right_pulse,
   output logic             E,
   output logic [DIR_W-1:0] heading,
   output logic             tick,
   output logic [CNT_W-1:0] q_count,
   output logic             drop
`ifdef TURN_QUEUE_DROP_COUNT_EN
   ,
   output logic [7:0]       drop_count
`endif
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   dir_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   dir_t             r_heading;
   logic             r_tick;
   logic             r_drop;
   logic             r_e;

   logic             w_rise;
   logic             w_req_valid;
   dir_t             w_req_dir;
   logic [PTR_W-1:0] w_tail_ptr;
   dir_t             w_ref_dir;
   logic             w_redundant;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   // SLOW_CLOCK high through reset release must not count as a game step.
   rise_detect #(
      .RESET_VAL (1'b1)
   ) u_slow_rise (
      .i_clk  (CLOCK),
      .i_rst  (RESET),
      .i_sig  (SLOW_CLOCK),
      .o_rise (w_rise)
   );

   always_comb begin
      w_req_valid = 1'b1;
      w_req_dir   = UP;
      if (up_pulse) begin
         w_req_dir = UP;
      end else if (down_pulse) begin
         w_req_dir = DOWN;
      end else if (left_pulse) begin
         w_req_dir = LEFT;
      end else if (right_pulse) begin
         w_req_dir = RIGHT;
      end else begin
         w_req_valid = 1'b0;
      end
   end

   // New turns are judged against the last queued turn, which is where the snake will be heading.
   assign w_tail_ptr  = (r_wr_ptr == '0) ? PTR_LAST : r_wr_ptr - 1'b1;
   assign w_ref_dir   = (r_count != '0) ? r_mem[w_tail_ptr] : r_heading;
   assign w_redundant = (w_req_dir == w_ref_dir) || (w_req_dir == opposite(w_ref_dir));
   assign w_full      = (r_count == CNT_FULL);
   assign w_pop       = w_rise && (r_count != '0);
   assign w_push      = w_req_valid && !w_redundant && (!w_full || w_pop);
   assign w_drop      = w_req_valid && !w_push;

   always_ff @(posedge CLOCK) begin
      if (w_push && !RESET) begin
         r_mem[r_wr_ptr] <= w_req_dir;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
         r_heading <= RESET_DIR;
         r_tick    <= 1'b0;
         r_drop    <= 1'b0;
         r_e       <= 1'b1;
      end else begin
         r_tick <= w_rise;
         r_drop <= w_drop;

         if (w_rise) begin
            r_e <= 1'b0;
         end else if (enable) begin
            r_e <= 1'b1;
         end

         if (w_pop) begin
            r_heading <= r_mem[r_rd_ptr];
            r_rd_ptr  <= ptr_inc(r_rd_ptr);
         end

         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end

         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

`ifdef TURN_QUEUE_DROP_COUNT_EN
   logic [7:0] r_drop_count;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != 8'hFF)) begin
         r_drop_count <= r_drop_count + 8'd1;
      end
   end

   assign drop_count = r_drop_count;
`endif

   assign E       = r_e;
   assign heading = r_heading;
   assign tick    = r_tick;
   assign q_count = r_count;
   assign drop    = r_drop;

endmodule

// File: tb/tb_turn_cmd_queue.sv
// Directed, table-driven bench for turn_cmd_queue with DEPTH=2 and RESET_DIR=RIGHT.
module tb_turn_cmd_queue;
   import snake_pkg::*;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic       SLOW_CLOCK;
   logic       enable;
   logic       up_pulse;
   logic       down_pulse;
   logic       left_pulse;
   logic       right_pulse;
   logic       E;
   logic [1:0] heading;
   logic       tick;
   logic [1:0] q_count;
   logic       drop;
`ifdef TURN_QUEUE_DROP_COUNT_EN
   logic [7:0] drop_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLOCK = ~CLOCK;

   turn_cmd_queue #(
      .DEPTH     (2),
      .RESET_DIR (RIGHT)
   ) dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .SLOW_CLOCK  (SLOW_CLOCK),
      .enable      (enable),
      .up_pulse    (up_pulse),
      .down_pulse  (down_pulse),
      .left_pulse  (left_pulse),
      .right_pulse (right_pulse),
      .E           (E),
      .heading     (heading),
      .tick        (tick),
      .q_count     (q_count),
      .drop        (drop)
`ifdef TURN_QUEUE_DROP_COUNT_EN
      ,
      .drop_count  (drop_count)
`endif
   );

   typedef struct {
      string      name;
      logic       slow;
      logic       en;
      logic [3:0] pulses;  // {up, down, left, right}
      logic [1:0] exp_heading;
      logic       exp_tick;
      logic [1:0] exp_count;
      logic       exp_drop;
      logic       exp_e;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic slow, input logic en,
                      input logic [3:0] pulses, input logic [1:0] h, input logic t,
                      input logic [1:0] c, input logic d, input logic e);
      vec_t v;
      v.name = name; v.slow = slow; v.en = en; v.pulses = pulses;
      v.exp_heading = h; v.exp_tick = t; v.exp_count = c; v.exp_drop = d; v.exp_e = e;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic slow, input logic en, input logic [3:0] pulses);
      SLOW_CLOCK  = slow;
      enable      = en;
      up_pulse    = pulses[3];
      down_pulse  = pulses[2];
      left_pulse  = pulses[1];
      right_pulse = pulses[0];
   endtask

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic check(input string name, input logic [1:0] h, input logic t,
                        input logic [1:0] c, input logic d, input logic e);
      checks++;
      if (heading !== h || tick !== t || q_count !== c || drop !== d || E !== e) begin
         errors++;
         $display("FAIL %s: got heading=%0d tick=%b count=%0d drop=%b E=%b, want heading=%0d tick=%b count=%0d drop=%b E=%b",
                  name, heading, tick, q_count, drop, E, h, t, c, d, e);
      end
   endtask

   localparam logic [3:0] NONE = 4'b0000;
   localparam logic [3:0] P_U  = 4'b1000;
   localparam logic [3:0] P_D  = 4'b0100;
   localparam logic [3:0] P_L  = 4'b0010;
   localparam logic [3:0] P_R  = 4'b0001;

   initial begin
      //   name              slow en pulses     heading tick cnt drop E
      add("no_tick_release",  1, 0, NONE,      RIGHT, 0, 0, 0, 1);
      add("idle_low",         0, 0, NONE,      RIGHT, 0, 0, 0, 1);
      add("push_up",          0, 0, P_U,       RIGHT, 0, 1, 0, 1);
      add("pop_up",           1, 0, NONE,      UP,    1, 0, 0, 0);
      add("tick_one_cycle",   1, 0, NONE,      UP,    0, 0, 0, 0);
      add("enable_sets_e",    0, 1, NONE,      UP,    0, 0, 0, 1);
      add("drop_reverse",     0, 0, P_D,       UP,    0, 0, 1, 1);
      add("drop_same",        0, 0, P_U,       UP,    0, 0, 1, 1);
      add("drop_one_cycle",   0, 0, NONE,      UP,    0, 0, 0, 1);
      add("push_left",        0, 0, P_L,       UP,    0, 1, 0, 1);
      add("push_up_full",     0, 0, P_U,       UP,    0, 2, 0, 1);
      add("drop_when_full",   0, 0, P_R,       UP,    0, 2, 1, 1);
      add("push_pop_full",    1, 0, P_L,       LEFT,  1, 2, 0, 0);
      add("hold_after_pp",    0, 0, NONE,      LEFT,  0, 2, 0, 0);
      add("pop_up_2",         1, 0, NONE,      UP,    1, 1, 0, 0);
      add("enable_again",     0, 1, NONE,      UP,    0, 1, 0, 1);
      add("clear_wins",       1, 1, NONE,      LEFT,  1, 0, 0, 0);
      add("priority_up",      0, 0, 4'b1010,   LEFT,  0, 1, 0, 0);
      add("pop_priority",     1, 0, NONE,      UP,    1, 0, 0, 0);
      add("slow_low",         0, 0, NONE,      UP,    0, 0, 0, 0);
      add("push_right",       0, 0, P_R,       UP,    0, 1, 0, 0);
      add("cnt1_filter_tail", 1, 0, P_L,       RIGHT, 1, 0, 1, 0);
      add("slow_low_2",       0, 0, NONE,      RIGHT, 0, 0, 0, 0);
      add("tick_empty_hold",  1, 0, NONE,      RIGHT, 1, 0, 0, 0);
      add("slow_low_3",       0, 0, NONE,      RIGHT, 0, 0, 0, 0);
      add("push_down",        0, 0, P_D,       RIGHT, 0, 1, 0, 0);
      add("drop_same_tail",   0, 0, P_D,       RIGHT, 0, 1, 1, 0);
      add("push_left_2",      0, 0, P_L,       RIGHT, 0, 2, 0, 0);

      RESET = 1'b1;
      drive(1'b1, 1'b0, NONE);
      step();
      step();
      check("reset_state", RIGHT, 1'b0, 2'd0, 1'b0, 1'b1);

      RESET = 1'b0;
      foreach (vecs[i]) begin
         drive(vecs[i].slow, vecs[i].en, vecs[i].pulses);
         step();
         check(vecs[i].name, vecs[i].exp_heading, vecs[i].exp_tick, vecs[i].exp_count,
               vecs[i].exp_drop, vecs[i].exp_e);
      end

      // Reset with two entries queued and a pulse plus a rise in flight.
      RESET = 1'b1;
      drive(1'b1, 1'b0, P_U);
      step();
      check("reset_mid_op", RIGHT, 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, NONE);
      step();
      RESET = 1'b0;
      step();
      check("no_tick_after_reset", RIGHT, 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, NONE);
      step();
      drive(1'b1, 1'b0, NONE);
      step();
      check("tick_after_reset", RIGHT, 1'b1, 2'd0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
